// File: rtl/vj_sched_pkg.sv
// Shared types, constants and helpers for the Viola-Jones scan-window scheduler.
// Also provides default pyramid geometry macros when the build does not set them.

`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 10
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 24
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd42, 32'd53, 32'd66, 32'd83, 32'd104, 32'd131, 32'd163, 32'd204, 32'd256, 32'd320}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd31, 32'd39, 32'd49, 32'd62, 32'd78, 32'd98, 32'd122, 32'd153, 32'd192, 32'd240}
`endif

package vj_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  // Level index presented while no window is being scanned.
  localparam logic [3:0]  IDX_NONE = 4'hF;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Last legal top-left position along one axis of a level.
  function automatic logic [31:0] last_pos(input logic [31:0] dim, input logic [31:0] window);
    return dim - window;
  endfunction

  // Saturating 32-bit increment for statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/scan_win_scheduler_if.sv
// Handshake bundle between the scan-window scheduler and its environment
// (frame capture in, vj pipeline out).

interface scan_win_scheduler_if;
  logic        img_rdy;
  logic        abort;
  logic        win_ready;
  logic        pipe_idle;
  logic        win_valid;
  logic [3:0]  img_index;
  logic [31:0] row_index;
  logic [31:0] col_index;
  logic        busy;
  logic        done;

  // Scheduler side.
  modport master (
    input  img_rdy, abort, win_ready, pipe_idle,
    output win_valid, img_index, row_index, col_index, busy, done
  );

  // Environment side: frame source plus vj pipeline.
  modport slave (
    output img_rdy, abort, win_ready, pipe_idle,
    input  win_valid, img_index, row_index, col_index, busy, done
  );
endinterface

// File: rtl/scan_coord_counter.sv
// Level/row/col raster counter for the scanning window.
// Parks at (IDX_NONE, 0, 0) after the last window of the last level or on clear.

module scan_coord_counter
  import vj_sched_pkg::*;
#(
  parameter int unsigned               LEVELS  = `PYRAMID_LEVELS,
  parameter int unsigned               WINDOW  = `WINDOW_SIZE,
  parameter logic [LEVELS-1:0][31:0]   WIDTHS  = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0]   HEIGHTS = `PYRAMID_HEIGHTS
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic        i_advance,
  output logic [3:0]  o_lvl,
  output logic [31:0] o_row,
  output logic [31:0] o_col,
  output logic        o_last_window
);

  logic [3:0]  r_lvl;
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic [31:0] w_last_col;
  logic [31:0] w_last_row;
  logic        w_last_lvl;

  // Look up the last row/col of the current level (no out-of-range indexing when parked).
  always_comb begin
    w_last_col = 32'd0;
    w_last_row = 32'd0;
    for (int i = 0; i < LEVELS; i++) begin
      w_last_col = (r_lvl == 4'(i)) ? last_pos(WIDTHS[i], 32'(WINDOW))  : w_last_col;
      w_last_row = (r_lvl == 4'(i)) ? last_pos(HEIGHTS[i], 32'(WINDOW)) : w_last_row;
    end
  end

  assign w_last_lvl    = (r_lvl == 4'(LEVELS - 1));
  assign o_last_window = w_last_lvl && (r_row == w_last_row) && (r_col == w_last_col);

  // Raster advance: col, then row, then level; park after the final window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lvl <= IDX_NONE;
      r_row <= 32'd0;
      r_col <= 32'd0;
    end else if (i_clear) begin
      r_lvl <= IDX_NONE;
      r_row <= 32'd0;
      r_col <= 32'd0;
    end else if (i_start) begin
      r_lvl <= 4'd0;
      r_row <= 32'd0;
      r_col <= 32'd0;
    end else if (i_advance) begin
      if (r_col != w_last_col) begin
        r_col <= r_col + 32'd1;
      end else if (r_row != w_last_row) begin
        r_col <= 32'd0;
        r_row <= r_row + 32'd1;
      end else if (!w_last_lvl) begin
        r_lvl <= r_lvl + 4'd1;
        r_row <= 32'd0;
        r_col <= 32'd0;
      end else begin
        r_lvl <= IDX_NONE;
        r_row <= 32'd0;
        r_col <= 32'd0;
      end
    end else begin
      r_lvl <= r_lvl;
      r_row <= r_row;
      r_col <= r_col;
    end
  end

  assign o_lvl = r_lvl;
  assign o_row = r_row;
  assign o_col = r_col;

endmodule

// File: rtl/scan_win_scheduler_chk.sv
// Simulation-only checks for the scan-window scheduler: pyramid geometry
// sanity and window hold-under-stall behaviour.

module scan_win_scheduler_chk #(
  parameter int unsigned             LEVELS  = `PYRAMID_LEVELS,
  parameter int unsigned             WINDOW  = `WINDOW_SIZE,
  parameter logic [LEVELS-1:0][31:0] WIDTHS  = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0] HEIGHTS = `PYRAMID_HEIGHTS
)(
  input logic        clock,
  input logic        reset,
  input logic        win_valid,
  input logic        win_ready,
  input logic        abort,
  input logic [3:0]  img_index,
  input logic [31:0] row_index,
  input logic [31:0] col_index
);

  logic w_cfg_ok;

  // Every level must be at least one window in both dimensions.
  always_comb begin
    w_cfg_ok = 1'b1;
    for (int i = 0; i < LEVELS; i++) begin
      w_cfg_ok = w_cfg_ok && (WIDTHS[i] >= 32'(WINDOW)) && (HEIGHTS[i] >= 32'(WINDOW));
    end
  end

  a_cfg_geometry: assert property (@(posedge clock) disable iff (reset) w_cfg_ok)
    else $error("pyramid level smaller than scanning window");

  a_hold_on_stall: assert property (@(posedge clock) disable iff (reset)
    (win_valid && !win_ready && !abort) |=>
      (win_valid && $stable(img_index) && $stable(row_index) && $stable(col_index)))
    else $error("window dropped or changed while stalled");

endmodule

// File: rtl/scan_win_scheduler.sv
// Scan-window scheduler: after each frame, waits a settle interval, issues every
// pyramid window (level, row, col) over a valid/ready handshake, drains the
// vj pipeline and pulses done. Frames arriving mid-scan are queued (one deep).
// Optional build macro SCAN_WIN_STATS_EN adds win_count/stall_count outputs.

module scan_win_scheduler
  import vj_sched_pkg::*;
#(
  parameter int unsigned             LEVELS        = `PYRAMID_LEVELS,
  parameter int unsigned             WINDOW        = `WINDOW_SIZE,
  parameter logic [LEVELS-1:0][31:0] WIDTHS        = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0] HEIGHTS       = `PYRAMID_HEIGHTS,
  parameter int unsigned             SETTLE_CYCLES = 76800
)(
  input  logic                 clock,
  input  logic                 reset,
  scan_win_scheduler_if.master bus
`ifdef SCAN_WIN_STATS_EN
  ,
  output logic [31:0]          win_count,
  output logic [31:0]          stall_count
`endif
);

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [31:0]  r_settle_cnt;
  logic [31:0]  w_settle_next;
  logic         r_pending;
  logic         w_pending_next;
  logic         r_win_valid;
  logic         r_busy;
  logic         r_done;
  logic         w_valid_next;
  logic         w_busy_next;
  logic         w_done_next;
  logic         w_transfer;
  logic         w_stall;
  logic         w_abort_act;
  logic         w_ctr_clear;
  logic         w_ctr_start;
  logic         w_ctr_advance;
  logic [3:0]   w_lvl;
  logic [31:0]  w_row;
  logic [31:0]  w_col;
  logic         w_last_window;

  assign w_transfer  = r_win_valid && bus.win_ready;
  assign w_stall     = r_win_valid && !bus.win_ready;
  assign w_abort_act = bus.abort && (r_state != IDLE);

  scan_coord_counter #(
    .LEVELS (LEVELS),
    .WINDOW (WINDOW),
    .WIDTHS (WIDTHS),
    .HEIGHTS(HEIGHTS)
  ) u_coord (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_ctr_clear),
    .i_start      (w_ctr_start),
    .i_advance    (w_ctr_advance),
    .o_lvl        (w_lvl),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_last_window(w_last_window)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; abort outranks every other event outside IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.img_rdy) w_state_next = WAIT;
        else             w_state_next = IDLE;
      end
      WAIT: begin
        if (bus.abort)                                    w_state_next = IDLE;
        else if (bus.img_rdy)                             w_state_next = WAIT;
        else if (r_settle_cnt == 32'(SETTLE_CYCLES))      w_state_next = SCAN;
        else                                              w_state_next = WAIT;
      end
      SCAN: begin
        if (bus.abort)                       w_state_next = IDLE;
        else if (w_transfer && w_last_window) w_state_next = DRAIN;
        else                                  w_state_next = SCAN;
      end
      DRAIN: begin
        if (bus.abort)                         w_state_next = IDLE;
        else if (!bus.pipe_idle)               w_state_next = DRAIN;
        else if (r_pending || bus.img_rdy)     w_state_next = WAIT;
        else                                   w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM output logic: next values of registered outputs, counters and pending flag.
  always_comb begin
    w_valid_next  = (w_state_next == SCAN);
    w_busy_next   = (w_state_next != IDLE);
    w_done_next   = (r_state == DRAIN) && !bus.abort && bus.pipe_idle;
    w_ctr_clear   = w_abort_act;
    w_ctr_start   = (r_state == WAIT) && (w_state_next == SCAN);
    w_ctr_advance = (r_state == SCAN) && w_transfer && !bus.abort;

    if (w_state_next != WAIT) begin
      w_settle_next = 32'd0;
    end else if ((r_state == WAIT) && !bus.img_rdy) begin
      w_settle_next = r_settle_cnt + 32'd1;
    end else begin
      w_settle_next = 32'd1;
    end

    if (w_abort_act) begin
      w_pending_next = 1'b0;
    end else if ((r_state == DRAIN) && (w_state_next != DRAIN)) begin
      w_pending_next = 1'b0;
    end else if (((r_state == SCAN) || (r_state == DRAIN)) && bus.img_rdy) begin
      w_pending_next = 1'b1;
    end else begin
      w_pending_next = r_pending;
    end
  end

  // Registered outputs, settle counter and pending-frame flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_settle_cnt <= 32'd0;
      r_pending    <= 1'b0;
    end else begin
      r_win_valid  <= w_valid_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_settle_cnt <= w_settle_next;
      r_pending    <= w_pending_next;
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.img_index = w_lvl;
  assign bus.row_index = w_row;
  assign bus.col_index = w_col;

`ifdef SCAN_WIN_STATS_EN
  logic [31:0] r_win_count;
  logic [31:0] r_stall_count;

  // Per-scan transfer and stall statistics; restart on scan entry or abort, hold after done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_count   <= 32'd0;
      r_stall_count <= 32'd0;
    end else if (w_ctr_clear || w_ctr_start) begin
      r_win_count   <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      r_win_count   <= w_ctr_advance ? sat_inc(r_win_count) : r_win_count;
      r_stall_count <= ((r_state == SCAN) && w_stall) ? sat_inc(r_stall_count) : r_stall_count;
    end
  end

  assign win_count   = r_win_count;
  assign stall_count = r_stall_count;
`endif

  scan_win_scheduler_chk #(
    .LEVELS (LEVELS),
    .WINDOW (WINDOW),
    .WIDTHS (WIDTHS),
    .HEIGHTS(HEIGHTS)
  ) u_chk (
    .clock    (clock),
    .reset    (reset),
    .win_valid(r_win_valid),
    .win_ready(bus.win_ready),
    .abort    (bus.abort),
    .img_index(w_lvl),
    .row_index(w_row),
    .col_index(w_col)
  );

endmodule

// File: tb/tb_scan_win_scheduler.sv
// Scoreboard bench for scan_win_scheduler: stimulus queues the expected window
// sequence, a negedge monitor pops and compares every accepted window.

module tb_scan_win_scheduler;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  scan_win_scheduler_if u_if();

`ifdef SCAN_WIN_STATS_EN
  logic [31:0] win_count;
  logic [31:0] stall_count;
`endif

  scan_win_scheduler #(
    .LEVELS       (2),
    .WINDOW       (2),
    .WIDTHS       ({32'd3, 32'd4}),
    .HEIGHTS      ({32'd3, 32'd3}),
    .SETTLE_CYCLES(4)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (u_if)
`ifdef SCAN_WIN_STATS_EN
    ,
    .win_count  (win_count),
    .stall_count(stall_count)
`endif
  );

  // Hand-computed raster order {level, row, col} for W={4,3}, H={3,3}, window 2.
  localparam logic [67:0] VEC [10] = '{
    {4'd0, 32'd0, 32'd0}, {4'd0, 32'd0, 32'd1}, {4'd0, 32'd0, 32'd2},
    {4'd0, 32'd1, 32'd0}, {4'd0, 32'd1, 32'd1}, {4'd0, 32'd1, 32'd2},
    {4'd1, 32'd0, 32'd0}, {4'd1, 32'd0, 32'd1},
    {4'd1, 32'd1, 32'd0}, {4'd1, 32'd1, 32'd1}
  };
  localparam logic [67:0] PARKED = {4'hF, 32'd0, 32'd0};

  int          errors;
  int          checks;
  int          done_cnt;
  logic [67:0] exp_q [$];

  initial begin
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
  end

  function automatic logic [67:0] coord();
    return {u_if.img_index, u_if.row_index, u_if.col_index};
  endfunction

  task automatic chk_vec(input string name, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_scan(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(VEC[i % 10]);
  endtask

  task automatic pulse_img();
    u_if.img_rdy = 1'b1;
    tick();
    u_if.img_rdy = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int k = 0; k < bound && done_cnt < target; k++) tick();
    chk_int("done_count", done_cnt, target);
  endtask

  // Monitor: pop-and-compare on every accepted window, hold check on stalls, count done.
  initial begin : monitor
    logic        prev_stall;
    logic [67:0] prev_c;
    logic [67:0] cur;
    prev_stall = 1'b0;
    prev_c     = '0;
    forever begin
      @(negedge clock);
      cur = coord();
      if (!reset && prev_stall) begin
        chk_bit("stall_valid_held", u_if.win_valid, 1'b1);
        chk_vec("stall_coord_stable", cur, prev_c);
      end
      if (!reset && u_if.win_valid && u_if.win_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %0h expected none", cur);
        end else begin
          chk_vec("window", cur, exp_q.pop_front());
        end
      end
      if (!reset && u_if.done) done_cnt++;
      prev_stall = !reset && u_if.win_valid && !u_if.win_ready && !u_if.abort;
      prev_c     = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] pat;
    reset          = 1'b1;
    u_if.img_rdy   = 1'b0;
    u_if.abort     = 1'b0;
    u_if.win_ready = 1'b1;
    u_if.pipe_idle = 1'b1;
    pat            = 4'b1001;
    repeat (3) @(posedge clock);
    #1;

    // Reset values.
    chk_bit("rst_win_valid", u_if.win_valid, 1'b0);
    chk_vec("rst_coord", coord(), PARKED);
    chk_bit("rst_busy", u_if.busy, 1'b0);
    chk_bit("rst_done", u_if.done, 1'b0);
`ifdef SCAN_WIN_STATS_EN
    chk_int("rst_win_count", int'(win_count), 0);
`endif
    reset = 1'b0;
    tick();

    // 1: free-flowing scan, first window SETTLE+1 cycles after img_rdy.
    push_scan(10);
    pulse_img();
    for (int k = 1; k <= 4; k++) begin
      chk_bit("t1_settle_no_valid", u_if.win_valid, 1'b0);
      chk_bit("t1_settle_busy", u_if.busy, 1'b1);
      tick();
    end
    chk_bit("t1_first_valid", u_if.win_valid, 1'b1);
    chk_vec("t1_first_coord", coord(), VEC[0]);
    wait_done(1, 40);
    chk_vec("t1_parked", coord(), PARKED);
    chk_bit("t1_idle_busy", u_if.busy, 1'b0);
    chk_int("t1_queue_empty", exp_q.size(), 0);

    // 2: win_ready pattern 1,0,0,1 -> 10 transfers, 10 stalls.
    push_scan(10);
    pulse_img();
    repeat (4) tick();
    for (int k = 0; k < 20; k++) begin
      u_if.win_ready = pat[k % 4];
      tick();
    end
    u_if.win_ready = 1'b1;
    wait_done(2, 20);
    chk_int("t2_queue_empty", exp_q.size(), 0);
`ifdef SCAN_WIN_STATS_EN
    chk_int("t2_win_count", int'(win_count), 10);
    chk_int("t2_stall_count", int'(stall_count), 10);
`endif

    // 3: pipe_idle low for 7 cycles after last transfer delays done.
    push_scan(10);
    u_if.pipe_idle = 1'b0;
    pulse_img();
    repeat (14) tick();
    chk_bit("t3_drain_valid", u_if.win_valid, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk_bit("t3_no_done", u_if.done, 1'b0);
      chk_bit("t3_busy", u_if.busy, 1'b1);
      tick();
    end
    u_if.pipe_idle = 1'b1;
    chk_bit("t3_no_done_yet", u_if.done, 1'b0);
    tick();
    chk_bit("t3_done", u_if.done, 1'b1);
    chk_bit("t3_done_busy", u_if.busy, 1'b0);
    tick();
    chk_int("t3_done_count", done_cnt, 3);

    // 4: second frame during SCAN chains straight into another scan.
    push_scan(20);
    pulse_img();
    repeat (7) tick();
    pulse_img();
    repeat (6) tick();
    chk_bit("t4_drain_busy", u_if.busy, 1'b1);
    tick();
    chk_bit("t4_done", u_if.done, 1'b1);
    chk_bit("t4_rewait_busy", u_if.busy, 1'b1);
    repeat (3) tick();
    chk_bit("t4_second_settle", u_if.win_valid, 1'b0);
    tick();
    chk_bit("t4_second_valid", u_if.win_valid, 1'b1);
    chk_vec("t4_second_coord", coord(), VEC[0]);
    wait_done(5, 40);
    chk_int("t4_queue_empty", exp_q.size(), 0);
    tick();
    chk_bit("t4_idle", u_if.busy, 1'b0);

    // 5: abort on the 3rd window while stalled, with a pending frame.
    push_scan(2);
    pulse_img();
    repeat (5) tick();
    u_if.img_rdy = 1'b1;
    tick();
    u_if.img_rdy   = 1'b0;
    u_if.win_ready = 1'b0;
    u_if.abort     = 1'b1;
    chk_bit("t5_third_valid", u_if.win_valid, 1'b1);
    chk_vec("t5_third_coord", coord(), VEC[2]);
    tick();
    u_if.abort     = 1'b0;
    u_if.win_ready = 1'b1;
    chk_bit("t5_abort_valid", u_if.win_valid, 1'b0);
    chk_vec("t5_abort_coord", coord(), PARKED);
    chk_bit("t5_abort_busy", u_if.busy, 1'b0);
    chk_bit("t5_abort_no_done", u_if.done, 1'b0);
`ifdef SCAN_WIN_STATS_EN
    chk_int("t5_abort_win_count", int'(win_count), 0);
`endif
    repeat (12) tick();
    chk_bit("t5_stays_idle", u_if.busy, 1'b0);
    chk_int("t5_done_count", done_cnt, 5);
    chk_int("t5_queue_empty", exp_q.size(), 0);

    // 5b: following scan must not chain (pending was cleared by abort).
    push_scan(10);
    pulse_img();
    wait_done(6, 40);
    repeat (8) tick();
    chk_bit("t5b_no_rescan", u_if.busy, 1'b0);

    // 6: asynchronous reset mid-SCAN.
    push_scan(2);
    pulse_img();
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_bit("t6_valid", u_if.win_valid, 1'b0);
    chk_vec("t6_coord", coord(), PARKED);
    chk_bit("t6_busy", u_if.busy, 1'b0);
    chk_bit("t6_done", u_if.done, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_int("t6_queue_empty", exp_q.size(), 0);
    chk_int("t6_done_count", done_cnt, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
